// File: rtl/mips_mmio_pkg.sv
// mips_mmio_pkg: MMIO offsets, CTRL/STATUS bit positions and timer states for the data-port responder.
package mips_mmio_pkg;
    localparam logic [4:0] OFS_GPIO_OUT   = 5'h00;
    localparam logic [4:0] OFS_GPIO_IN    = 5'h04;
    localparam logic [4:0] OFS_TIMER_CNT  = 5'h08;
    localparam logic [4:0] OFS_TIMER_CMP  = 5'h0C;
    localparam logic [4:0] OFS_TIMER_CTRL = 5'h10;
    localparam logic [4:0] OFS_STATUS     = 5'h14;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int ST_MATCH  = 0;
    localparam int ST_ERR    = 1;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} t_state_e;

    function automatic logic ofs_writable(input logic [4:0] o, input logic tmr);
        return o == OFS_GPIO_OUT || o == OFS_STATUS ||
               (tmr && (o == OFS_TIMER_CNT || o == OFS_TIMER_CMP || o == OFS_TIMER_CTRL));
    endfunction
endpackage

// File: rtl/mips_mmio_timer.sv
// mips_mmio_timer: compare timer (CNT, CMP, CTRL, FSM); instantiated only when MIPS_MMIO_TIMER_EN is defined.
module mips_mmio_timer
    import mips_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ofs,
    input  logic [31:0] wdata,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output logic [1:0]  ctrl,
    output logic        match
);
    t_state_e st, st_n;
    logic cnt_we, cmp_we, ctrl_we, one_shot_end;

    assign cnt_we       = we && ofs == OFS_TIMER_CNT;
    assign cmp_we       = we && ofs == OFS_TIMER_CMP;
    assign ctrl_we      = we && ofs == OFS_TIMER_CTRL;
    assign match        = st == T_RUN && cnt == cmp;
    assign one_shot_end = match && !ctrl[CTRL_AR];

    always_comb begin
        st_n = st;
        if (ctrl_we)
            st_n = wdata[CTRL_EN] ? T_RUN : T_IDLE;
        else if (st == T_IDLE && ctrl[CTRL_EN])
            st_n = T_RUN;
        else if (one_shot_end)
            st_n = T_DONE;
    end

    // Core writes take priority over increment, reload and the one-shot en clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= T_IDLE;
            cnt  <= '0;
            cmp  <= '1;
            ctrl <= '0;
        end else begin
            st <= st_n;
            if (cnt_we)
                cnt <= wdata;
            else if (match)
                cnt <= ctrl[CTRL_AR] ? '0 : cnt;
            else if (st == T_RUN)
                cnt <= cnt + 32'd1;
            if (cmp_we)
                cmp <= wdata;
            if (ctrl_we)
                ctrl <= wdata[1:0];
            else if (one_shot_end)
                ctrl[CTRL_EN] <= 1'b0;
        end
    end
endmodule

// File: rtl/mips_dmem_mmio_responder.sv
// mips_dmem_mmio_responder: MIPS data-port responder (RAM + GPIO/timer/status MMIO).
// Timer is present only when MIPS_MMIO_TIMER_EN is defined.
module mips_dmem_mmio_responder
    import mips_mmio_pkg::*;
#(
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00,
    parameter int          GPIO_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ALUOut,
    input  logic [31:0]       WriteData,
    input  logic              MemWrite,
    output logic [31:0]       ReadData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              addr_err
);
    localparam int AW = $clog2(DMEM_WORDS);
`ifdef MIPS_MMIO_TIMER_EN
    localparam logic TMR = 1'b1;
`else
    localparam logic TMR = 1'b0;
`endif

    logic [31:0]       mem [DMEM_WORDS];
    logic              ram_hit, mmio_hit, aligned, wr_ok, wr, mmio_we, sts_we, err_set, match;
    logic [4:0]        ofs, rofs;
    logic [GPIO_W-1:0] gsync1, gsync2;
    logic [1:0]        status, ctrl;
    logic [31:0]       cnt, cmp, mmio_rd;

    assign ram_hit  = ALUOut < 32'(DMEM_WORDS * 4);
    assign mmio_hit = ALUOut >= MMIO_BASE && ALUOut <= MMIO_BASE + 32'h1F;
    assign ofs      = ALUOut[4:0] - MMIO_BASE[4:0];
    assign rofs     = {ofs[4:2], 2'b00};
    assign aligned  = ALUOut[1:0] == 2'b00;
    assign wr_ok    = aligned && (ram_hit || (mmio_hit && ofs_writable(ofs, TMR)));
    assign wr       = MemWrite && wr_ok;
    assign err_set  = MemWrite && !wr_ok;
    assign mmio_we  = wr && mmio_hit;
    assign sts_we   = mmio_we && ofs == OFS_STATUS;

`ifdef MIPS_MMIO_TIMER_EN
    mips_mmio_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .we    (mmio_we),
        .ofs   (ofs),
        .wdata (WriteData),
        .cnt   (cnt),
        .cmp   (cmp),
        .ctrl  (ctrl),
        .match (match)
    );
`else
    assign cnt   = '0;
    assign cmp   = '0;
    assign ctrl  = '0;
    assign match = 1'b0;
`endif

    always_comb begin
        mmio_rd = rofs == OFS_GPIO_OUT   ? 32'(gpio_out) :
                  rofs == OFS_GPIO_IN    ? 32'(gsync2) :
                  rofs == OFS_TIMER_CNT  ? cnt :
                  rofs == OFS_TIMER_CMP  ? cmp :
                  rofs == OFS_TIMER_CTRL ? {30'd0, ctrl} :
                  rofs == OFS_STATUS     ? {30'd0, status} : '0;
        ReadData = ram_hit ? mem[ALUOut[AW+1:2]] : mmio_hit ? mmio_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (wr && ram_hit && !reset)
            mem[ALUOut[AW+1:2]] <= WriteData;
    end

    // Hardware set of match/err wins over a write-1-to-clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            gsync1   <= '0;
            gsync2   <= '0;
            gpio_out <= '0;
            status   <= '0;
        end else begin
            gsync1 <= gpio_in;
            gsync2 <= gsync1;
            if (mmio_we && ofs == OFS_GPIO_OUT)
                gpio_out <= WriteData[GPIO_W-1:0];
            status[ST_MATCH] <= match | (status[ST_MATCH] & ~(sts_we & WriteData[ST_MATCH]));
            status[ST_ERR]   <= err_set | (status[ST_ERR] & ~(sts_we & WriteData[ST_ERR]));
        end
    end

    assign timer_irq = status[ST_MATCH];
    assign addr_err  = status[ST_ERR];
endmodule
